// File: rtl/vga_plot_arbiter_if.sv
// Plot-port bundle between the pixel sources and the shared VGA plot arbiter.
// Latency: none; wiring only.
// Backpressure: sources hold req/data until ack; the arbiter drives ack, grant and the plot outputs.
interface vga_plot_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int C_W     = 3
);
  logic                     en;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*X_W-1:0]   x_in;
  logic [NUM_REQ*Y_W-1:0]   y_in;
  logic [NUM_REQ*C_W-1:0]   colour_in;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       grant;
  logic                     plot;
  logic [X_W-1:0]           x_out;
  logic [Y_W-1:0]           y_out;
  logic [C_W-1:0]           colour_out;

  // Sources and the enable side: drive requests and pixels, observe the arbiter.
  modport master (
    output en, req, x_in, y_in, colour_in,
    input  ack, grant, plot, x_out, y_out, colour_out
  );

  // Arbiter side.
  modport slave (
    input  en, req, x_in, y_in, colour_in,
    output ack, grant, plot, x_out, y_out, colour_out
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one VGA plot port between NUM_REQ pixel sources, bounded bursts.
// Latency: 1 ARB cycle per grant; a pixel reaches plot/x/y/colour 1 cycle after its ack.
// Backpressure: req/data held until ack (combinational); en=0 freezes all accepts and state.
module vga_plot_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int C_W       = 3,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  vga_plot_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, SERVE} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [CNT_W-1:0] burst_cnt;
  logic [PTR_W-1:0] pick;
  logic             pick_vld;
  logic             accept;
  logic             last_beat;
  logic             release_src;
  int               idx;

  // Pointer successor modulo NUM_REQ (works for non power-of-two counts).
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (int'(p) >= NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_vld && bus.req[idx]) begin
        pick_vld = 1'b1;
        pick     = PTR_W'(idx);
      end
    end
  end

  // A pixel is taken only while serving, enabled, and never in a reset cycle (it would be lost).
  always_comb begin
    accept      = (state == SERVE) && bus.en && bus.req[owner] && !rst;
    last_beat   = accept && (burst_cnt == CNT_W'(MAX_BURST - 1));
    release_src = bus.en && !bus.req[owner];
    bus.ack     = '0;
    if (accept) bus.ack[owner] = 1'b1;
  end

  // Arbitration FSM with registered grant and plot outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ARB;
      rr_ptr         <= '0;
      owner          <= '0;
      burst_cnt      <= '0;
      bus.grant      <= '0;
      bus.plot       <= 1'b0;
      bus.x_out      <= '0;
      bus.y_out      <= '0;
      bus.colour_out <= '0;
    end else begin
      case (state)
        ARB: begin
          bus.plot <= 1'b0;
          if (bus.en && pick_vld) begin
            owner     <= pick;
            bus.grant <= NUM_REQ'(1) << pick;
            burst_cnt <= '0;
            state     <= SERVE;
          end
        end
        SERVE: begin
          bus.plot <= accept;
          if (accept) begin
            bus.x_out      <= bus.x_in[owner*X_W +: X_W];
            bus.y_out      <= bus.y_in[owner*Y_W +: Y_W];
            bus.colour_out <= bus.colour_in[owner*C_W +: C_W];
            burst_cnt      <= burst_cnt + 1'b1;
          end
          // Burst exhausted or source let go: hand the port on to the next index.
          if (last_beat || release_src) begin
            state     <= ARB;
            bus.grant <= '0;
            rr_ptr    <= next_ptr(owner);
            burst_cnt <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for the VGA plot arbiter: directed vector table, corner-case sequences, randomized traffic.
// Inputs change 1 time unit after posedge; outputs are sampled on the falling edge.
// Expected values come from constants and a transaction-level round-robin model.
module tb_vga_plot_arbiter;
  localparam int N  = 3;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_plot_arbiter_if #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW)) bus ();

  vga_plot_arbiter #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int plot_cnt = 0;
  int sx[N];
  int sy[N];
  int sc[N];

  typedef struct {
    bit           r;
    bit           e;
    logic [N-1:0] q;
    logic [N-1:0] g;
    logic [N-1:0] a;
    bit           p;
    int           x;
    int           y;
    int           c;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) begin
      bus.x_in[i*XW +: XW]      = XW'(sx[i]);
      bus.y_in[i*YW +: YW]      = YW'(sy[i]);
      bus.colour_in[i*CW +: CW] = CW'(sc[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Apply one cycle of inputs, check outputs at the falling edge, then advance.
  task automatic step_chk(input string nm, input bit r, input bit e, input logic [N-1:0] q,
                          input logic [N-1:0] g, input logic [N-1:0] a, input bit p,
                          input int ex = -1, input int ey = -1, input int ec = -1);
    rst = r;
    bus.en = e;
    bus.req = q;
    @(negedge clk);
    check({nm, ".grant"}, int'(bus.grant), int'(g));
    check({nm, ".ack"},   int'(bus.ack),   int'(a));
    check({nm, ".plot"},  int'(bus.plot),  int'(p));
    if (ex >= 0) check({nm, ".x"},      int'(bus.x_out),      ex);
    if (ey >= 0) check({nm, ".y"},      int'(bus.y_out),      ey);
    if (ec >= 0) check({nm, ".colour"}, int'(bus.colour_out), ec);
    if (bus.plot) plot_cnt++;
    tick();
  endtask

  // Reference model state: who owns the port, pixels taken this grant, rotation pointer, last pixel.
  bit           m_busy;
  int           m_owner;
  int           m_cnt;
  int           m_ptr;
  bit           m_plot;
  int           m_x;
  int           m_y;
  int           m_c;
  logic [N-1:0] exp_g;
  logic [N-1:0] exp_a;
  logic [N-1:0] last_ack;

  initial begin
    rst = 1'b1;
    bus.en = 1'b1;
    bus.req = '1;
    sx = '{1, 10, 200};
    sy = '{2, 20, 100};
    sc = '{1, 4, 7};
    drive_data();
    tick();

    // Reset with all requests high, then the snake source alone for a full burst and a release.
    tbl[0]  = '{1, 1, 3'b111, 3'b000, 3'b000, 0,  0,  0, 0};
    tbl[1]  = '{1, 1, 3'b111, 3'b000, 3'b000, 0,  0,  0, 0};
    tbl[2]  = '{0, 1, 3'b010, 3'b000, 3'b000, 0,  0,  0, 0};
    tbl[3]  = '{0, 1, 3'b010, 3'b010, 3'b010, 0,  0,  0, 0};
    tbl[4]  = '{0, 1, 3'b010, 3'b010, 3'b010, 1, 10, 20, 4};
    tbl[5]  = '{0, 1, 3'b010, 3'b010, 3'b010, 1, 10, 20, 4};
    tbl[6]  = '{0, 1, 3'b010, 3'b010, 3'b010, 1, 10, 20, 4};
    tbl[7]  = '{0, 1, 3'b010, 3'b000, 3'b000, 1, 10, 20, 4};
    tbl[8]  = '{0, 1, 3'b010, 3'b010, 3'b010, 0, 10, 20, 4};
    tbl[9]  = '{0, 1, 3'b000, 3'b010, 3'b000, 1, 10, 20, 4};
    tbl[10] = '{0, 1, 3'b000, 3'b000, 3'b000, 0, 10, 20, 4};
    for (int i = 0; i < 11; i++) begin
      step_chk($sformatf("vec%0d", i), tbl[i].r, tbl[i].e, tbl[i].q, tbl[i].g, tbl[i].a,
               tbl[i].p, tbl[i].x, tbl[i].y, tbl[i].c);
    end

    // All three requesting: grants rotate 0,1,2,0, each MB pixels then one ARB gap.
    do_reset();
    for (int cyc = 0; cyc < 4 * (MB + 1); cyc++) begin
      int grp;
      int ph;
      int own;
      logic [N-1:0] oh;
      grp = cyc / (MB + 1);
      ph  = cyc % (MB + 1);
      own = grp % N;
      oh  = N'(1) << own;
      step_chk($sformatf("rr%0d", cyc), 0, 1, 3'b111,
               (ph == 0) ? 3'b000 : oh, (ph == 0) ? 3'b000 : oh,
               (ph >= 2) || (ph == 0 && cyc > 0),
               (ph >= 2) ? sx[own] : ((ph == 0 && cyc > 0) ? sx[(grp + N - 1) % N] : -1));
    end

    // Freeze mid-burst for source 2: grant held, burst continues at the same count afterwards.
    do_reset();
    step_chk("frz0", 0, 1, 3'b100, 3'b000, 3'b000, 0);
    step_chk("frz1", 0, 1, 3'b100, 3'b100, 3'b100, 0);
    step_chk("frz2", 0, 1, 3'b100, 3'b100, 3'b100, 1, 200, 100, 7);
    step_chk("frz3", 0, 0, 3'b100, 3'b100, 3'b000, 1, 200, 100, 7);
    step_chk("frz4", 0, 0, 3'b100, 3'b100, 3'b000, 0);
    step_chk("frz5", 0, 0, 3'b100, 3'b100, 3'b000, 0);
    step_chk("frz6", 0, 1, 3'b100, 3'b100, 3'b100, 0);
    step_chk("frz7", 0, 1, 3'b100, 3'b100, 3'b100, 1);
    step_chk("frz8", 0, 1, 3'b100, 3'b000, 3'b000, 1);
    step_chk("frz9", 0, 1, 3'b100, 3'b100, 3'b100, 0);

    // Source 0 releases after two pixels; source 1 gets the port after one ARB cycle.
    do_reset();
    plot_cnt = 0;
    step_chk("rel0", 0, 1, 3'b011, 3'b000, 3'b000, 0);
    step_chk("rel1", 0, 1, 3'b011, 3'b001, 3'b001, 0);
    step_chk("rel2", 0, 1, 3'b011, 3'b001, 3'b001, 1, 1, 2, 1);
    step_chk("rel3", 0, 1, 3'b010, 3'b001, 3'b000, 1, 1, 2, 1);
    step_chk("rel4", 0, 1, 3'b010, 3'b000, 3'b000, 0);
    check("rel.src0_plots", plot_cnt, 2);
    step_chk("rel5", 0, 1, 3'b010, 3'b010, 3'b010, 0);

    // Reset the cycle after an ack: no ack during reset, pixel dropped, fresh grant goes to 0.
    do_reset();
    step_chk("mrst0", 0, 1, 3'b010, 3'b000, 3'b000, 0);
    step_chk("mrst1", 0, 1, 3'b010, 3'b010, 3'b010, 0);
    step_chk("mrst2", 1, 1, 3'b010, 3'b010, 3'b000, 1, 10, 20, 4);
    step_chk("mrst3", 0, 1, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0);
    step_chk("mrst4", 0, 1, 3'b111, 3'b001, 3'b001, 0, 0, 0, 0);

    // Randomized traffic against the round-robin model.
    do_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    m_plot = 0; m_x = 0; m_y = 0; m_c = 0;
    last_ack = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (last_ack[i] || !bus.req[i]) begin
          if (last_ack[i] && ($urandom % 2 == 0)) begin
            bus.req[i] = 1'b0;
          end else if (last_ack[i] || ($urandom % 3 == 0)) begin
            bus.req[i] = 1'b1;
            sx[i] = int'($urandom % 256);
            sy[i] = int'($urandom % 128);
            sc[i] = int'($urandom % 8);
          end
        end
      end
      drive_data();
      bus.en = ($urandom % 8) != 0;
      @(negedge clk);
      exp_g = m_busy ? (N'(1) << m_owner) : '0;
      exp_a = (m_busy && bus.en && bus.req[m_owner]) ? exp_g : '0;
      check("rnd.grant",  int'(bus.grant), int'(exp_g));
      check("rnd.ack",    int'(bus.ack),   int'(exp_a));
      check("rnd.plot",   int'(bus.plot),  int'(m_plot));
      check("rnd.pixel",  int'({bus.x_out, bus.y_out, bus.colour_out}),
            (m_x << (YW + CW)) | (m_y << CW) | m_c);
      last_ack = exp_a;
      // Advance the model by one clock edge.
      if (!m_busy) begin
        m_plot = 0;
        if (bus.en && bus.req != 0) begin
          for (int k = N - 1; k >= 0; k--) begin
            if (bus.req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
          end
          m_busy = 1;
          m_cnt = 0;
        end
      end else begin
        m_plot = exp_a != 0;
        if (m_plot) begin
          m_x = sx[m_owner]; m_y = sy[m_owner]; m_c = sc[m_owner];
          m_cnt++;
        end
        if ((m_plot && m_cnt == MB) || (bus.en && !bus.req[m_owner])) begin
          m_busy = 0;
          m_ptr = (m_owner + 1) % N;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
